// File: rtl/cp0_defs.sv
// ============================================================================
// Module      : cp0_defs (package)
// Description : Shared CP0 register numbers, exception codes and field masks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;
    localparam logic [4:0] EXCCODE_TR   = 5'h0d;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_TI_BIT   = 30;
    localparam int CAUSE_BD_BIT   = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    typedef enum logic [1:0] {
        CMT_NONE = 2'd0,
        CMT_ERET = 2'd1,
        CMT_EXC  = 2'd2,
        CMT_MTC0 = 2'd3
    } cp0_commit_e;

    function automatic logic [4:0] exccode_of(input logic [31:0] et);
        case (et)
            EXC_INT:  return EXCCODE_INT;
            EXC_ADEL: return EXCCODE_ADEL;
            EXC_ADES: return EXCCODE_ADES;
            EXC_SYS:  return EXCCODE_SYS;
            EXC_BP:   return EXCCODE_BP;
            EXC_RI:   return EXCCODE_RI;
            EXC_OV:   return EXCCODE_OV;
            EXC_TR:   return EXCCODE_TR;
            default:  return et[4:0];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : CP0 Count/Compare timer; Count advances once every two clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick    <= 1'b0;
            r_count   <= 32'h0;
            r_compare <= 32'h0;
            r_ti      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;

            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end

            // Writing Compare acknowledges the interrupt and beats a same-cycle match
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if ((r_compare != 32'h0) && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
// ============================================================================
// Module      : cp0_regfile
// Description : MIPS CP0 register file: exception state, MFC0/MTC0, timer IRQ.
//               Define CP0_TIMER_EN to implement Count/Compare and Cause.TI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h00004220,
    parameter logic [31:0] STATUS_RST = 32'h00400000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] badaddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_cause_bd;
    logic [5:0]  r_cause_iphw;
    logic [1:0]  r_cause_ipsw;
    logic [4:0]  r_cause_exc;

    cp0_commit_e w_commit;
    logic        w_wr;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_cause;

    // ERET outranks other exceptions, which outrank MTC0; a stalled stage commits nothing
    always_comb begin
        w_commit = CMT_NONE;
        if (en_i) begin
            if (excepttype_i == EXC_ERET) begin
                w_commit = CMT_ERET;
            end else if (excepttype_i != EXC_NONE) begin
                w_commit = CMT_EXC;
            end else if (we_i) begin
                w_commit = CMT_MTC0;
            end
        end
    end

    assign w_wr = (w_commit == CMT_MTC0);

`ifdef CP0_TIMER_EN
    logic w_count_we;
    logic w_compare_we;

    assign w_count_we   = w_wr && (waddr_i == CP0_COUNT);
    assign w_compare_we = w_wr && (waddr_i == CP0_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (wdata_i),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );
`else
    assign w_count   = 32'h0;
    assign w_compare = 32'h0;
    assign w_ti      = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status     <= STATUS_RST;
            r_epc        <= 32'h0;
            r_badvaddr   <= 32'h0;
            r_cause_bd   <= 1'b0;
            r_cause_iphw <= 6'h0;
            r_cause_ipsw <= 2'h0;
            r_cause_exc  <= 5'h0;
        end else begin
            // Hardware interrupt pending bits track the pins even while stalled
            r_cause_iphw <= {int_i[5] | w_ti, int_i[4:0]};

            case (w_commit)
                CMT_ERET: begin
                    r_status[STATUS_EXL_BIT] <= 1'b0;
                end
                CMT_EXC: begin
                    if (!r_status[STATUS_EXL_BIT]) begin
                        r_epc      <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                        r_cause_bd <= in_delayslot_i;
                    end
                    r_status[STATUS_EXL_BIT] <= 1'b1;
                    r_cause_exc              <= exccode_of(excepttype_i);
                    if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
                        r_badvaddr <= badaddr_i;
                    end
                end
                CMT_MTC0: begin
                    case (waddr_i)
                        CP0_STATUS: r_status <= (r_status & ~STATUS_WMASK) |
                                                (wdata_i & STATUS_WMASK);
                        CP0_CAUSE:  r_cause_ipsw <= wdata_i[9:8];
                        CP0_EPC:    r_epc <= wdata_i;
                        default:    ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign w_cause = {r_cause_bd, w_ti, 14'h0, r_cause_iphw, r_cause_ipsw,
                      1'b0, r_cause_exc, 2'b00};

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = r_badvaddr;
            CP0_COUNT:    rdata_o = w_count;
            CP0_COMPARE:  rdata_o = w_compare;
            CP0_STATUS:   rdata_o = r_status;
            CP0_CAUSE:    rdata_o = w_cause;
            CP0_EPC:      rdata_o = r_epc;
            CP0_PRID:     rdata_o = PRID_VALUE;
            default:      rdata_o = 32'h0;
        endcase
    end

    assign status_o    = r_status;
    assign cause_o     = w_cause;
    assign epc_o       = r_epc;
    assign timer_int_o = w_ti;

endmodule

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
// ============================================================================
// Module      : tb_cp0_regfile
// Description : Self-checking bench for cp0_regfile (either CP0_TIMER_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_regfile;

    logic        clk;
    logic        resetn;
    logic        en_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] badaddr_i;
    logic [5:0]  int_i;
    logic [31:0] rdata_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    cp0_regfile dut (
        .clk            (clk),
        .resetn         (resetn),
        .en_i           (en_i),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .badaddr_i      (badaddr_i),
        .int_i          (int_i),
        .rdata_o        (rdata_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .timer_int_o    (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected read value is queued with the address, then retired once rdata settles
    task automatic expect_rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        raddr_i = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, rdata_o, e);
    endtask

    task automatic idle_inputs();
        en_i           = 1'b1;
        we_i           = 1'b0;
        waddr_i        = 5'd0;
        wdata_i        = 32'h0;
        excepttype_i   = 32'h0;
        pc_i           = 32'h0;
        in_delayslot_i = 1'b0;
        badaddr_i      = 32'h0;
    endtask

    task automatic commit(input logic en, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [31:0] et,
                          input logic [31:0] pc, input logic ds, input logic [31:0] bad);
        en_i           = en;
        we_i           = we;
        waddr_i        = wa;
        wdata_i        = wd;
        excepttype_i   = et;
        pc_i           = pc;
        in_delayslot_i = ds;
        badaddr_i      = bad;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        commit(1'b1, 1'b1, wa, wd, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic exc(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
        commit(1'b1, 1'b0, 5'd0, 32'h0, et, pc, ds, bad);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        resetn  = 1'b0;
        raddr_i = 5'd0;
        int_i   = 6'h0;
        idle_inputs();
        cycles(3);
        resetn = 1'b1;
        cycles(1);

        expect_rd(5'd12, 32'h00400000, "rst_status");
        expect_rd(5'd13, 32'h00000000, "rst_cause");
        expect_rd(5'd14, 32'h00000000, "rst_epc");
        expect_rd(5'd15, 32'h00004220, "prid");
        expect_rd(5'd8,  32'h00000000, "rst_badvaddr");

        // syscall outside a delay slot, then ERET
        exc(32'h8, 32'hBFC00100, 1'b0, 32'h0);
        expect_rd(5'd14, 32'hBFC00100, "sys_epc");
        expect_rd(5'd13, 32'h00000020, "sys_cause");
        expect_rd(5'd12, 32'h00400002, "sys_status");
        exc(32'he, 32'h0, 1'b0, 32'h0);
        expect_rd(5'd12, 32'h00400000, "eret_status");
        expect_rd(5'd13, 32'h00000020, "eret_cause");

        // AdEL in a delay slot, then nested AdES while EXL=1
        exc(32'h4, 32'hBFC00208, 1'b1, 32'h00000003);
        expect_rd(5'd14, 32'hBFC00204, "adel_epc");
        expect_rd(5'd13, 32'h80000010, "adel_cause");
        expect_rd(5'd8,  32'h00000003, "adel_badv");
        exc(32'h5, 32'hBFC00300, 1'b0, 32'h00000010);
        expect_rd(5'd14, 32'hBFC00204, "nest_epc_held");
        expect_rd(5'd13, 32'h80000014, "nest_cause");
        expect_rd(5'd8,  32'h00000010, "nest_badv");
        exc(32'he, 32'h0, 1'b0, 32'h0);

        // masked writes and commit conflicts
        mtc0(5'd12, 32'hFFFFFFFF);
        expect_rd(5'd12, 32'h0040FF03, "status_mask");
        exc(32'he, 32'h0, 1'b0, 32'h0);
        expect_rd(5'd12, 32'h0040FF01, "status_eret");
        commit(1'b1, 1'b1, 5'd14, 32'h00001234, 32'hc, 32'hBFC00400, 1'b0, 32'h0);
        expect_rd(5'd14, 32'hBFC00400, "conflict_epc");
        expect_rd(5'd13, 32'h00000030, "ov_cause");
        expect_rd(5'd12, 32'h0040FF03, "ov_status");
        exc(32'he, 32'h0, 1'b0, 32'h0);
        commit(1'b0, 1'b0, 5'd0, 32'h0, 32'h8, 32'h0000DEAD, 1'b1, 32'h0);
        expect_rd(5'd12, 32'h0040FF01, "stall_status");
        expect_rd(5'd14, 32'hBFC00400, "stall_epc");
        expect_rd(5'd13, 32'h00000030, "stall_cause");
        commit(1'b0, 1'b1, 5'd14, 32'h00005555, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_rd(5'd14, 32'hBFC00400, "stall_mtc0");

        mtc0(5'd13, 32'hFFFFFFFF);
        expect_rd(5'd13, 32'h00000330, "cause_mask");
        mtc0(5'd12, 32'h00000000);
        expect_rd(5'd12, 32'h00400000, "status_bev_kept");
        mtc0(5'd3, 32'hFFFFFFFF);
        expect_rd(5'd3, 32'h00000000, "unmapped");
        mtc0(5'd8, 32'h0000FFFF);
        expect_rd(5'd8, 32'h00000010, "badv_ro");
        mtc0(5'd15, 32'hFFFFFFFF);
        expect_rd(5'd15, 32'h00004220, "prid_ro");

        // hardware interrupt lines sampled every cycle, even while stalled
        int_i = 6'b101010;
        commit(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_rd(5'd13, 32'h0000AB30, "hw_ip");
        int_i = 6'h0;
        cycles(1);
        expect_rd(5'd13, 32'h00000330, "hw_ip_clear");

`ifdef CP0_TIMER_EN
        begin
            int cyc;
            mtc0(5'd11, 32'd5);
            expect_rd(5'd11, 32'd5, "compare_wr");
            mtc0(5'd9, 32'd0);
            expect_rd(5'd9, 32'd0, "count_wr");
            cyc = 0;
            while (!timer_int_o && cyc < 40) begin
                cycles(1);
                cyc++;
            end
            check_eq("ti_set", {31'h0, timer_int_o}, 32'd1);
            expect_rd(5'd13, 32'h40000330, "ti_cause");
            cycles(1);
            expect_rd(5'd13, 32'h40008330, "ti_ip7");
            mtc0(5'd11, 32'd100);
            check_eq("ti_clear", {31'h0, timer_int_o}, 32'd0);
            expect_rd(5'd13, 32'h00008330, "ti_clr_cause");
            cycles(1);
            expect_rd(5'd13, 32'h00000330, "ip7_clear");
            mtc0(5'd9, 32'hFFFFFFFF);
            cycles(2);
            expect_rd(5'd9, 32'h00000000, "count_wrap");
            check_eq("wrap_no_ti", {31'h0, timer_int_o}, 32'd0);
            mtc0(5'd9, 32'd37);
            expect_rd(5'd9, 32'd37, "count_37");
        end
`else
        mtc0(5'd11, 32'd5);
        expect_rd(5'd11, 32'd0, "no_compare");
        mtc0(5'd9, 32'd7);
        expect_rd(5'd9, 32'd0, "no_count");
        cycles(12);
        check_eq("no_ti", {31'h0, timer_int_o}, 32'd0);
        expect_rd(5'd13, 32'h00000330, "no_ti_cause");
`endif

        // asynchronous reset in the middle of a cycle with EXL set
        exc(32'h8, 32'hBFC00500, 1'b0, 32'h0);
        expect_rd(5'd12, 32'h00400002, "pre_rst_status");
        resetn = 1'b0;
        #1;
        expect_rd(5'd12, 32'h00400000, "arst_status");
        expect_rd(5'd13, 32'h00000000, "arst_cause");
        expect_rd(5'd14, 32'h00000000, "arst_epc");
        expect_rd(5'd8,  32'h00000000, "arst_badv");
        expect_rd(5'd9,  32'h00000000, "arst_count");
        expect_rd(5'd11, 32'h00000000, "arst_compare");
        check_eq("arst_ti", {31'h0, timer_int_o}, 32'd0);
        check_eq("arst_epc_o", epc_o, 32'h0);
        check_eq("arst_status_o", status_o, 32'h00400000);
        cycles(2);
        resetn = 1'b1;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
Coprocessor-0 register file for the 5-stage MIPS pipeline.
- Receives the M-stage exception type and records exception state: EPC, Cause, Status.EXL, BadVAddr.
- Serves MFC0/MTC0 accesses.
- Supplies cp0_epc to the hazard unit for ERET redirect.
- Generates the timer interrupt request, sampled into Cause.IP7.

Parameters:
- PRID_VALUE, 32'h00004220, read-only value of PRId (reg 15).
- STATUS_RST, 32'h00400000, Status reset value (BEV=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- en_i  in  1  commit enable; driven ~stallM; no state update when 0 (timer still runs)
- we_i  in  1  MTC0 write strobe (M stage)
- waddr_i  in  5  MTC0 register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 register number
- excepttype_i  in  32  M-stage exception code: 0 none, 1 int, 4 AdEL, 5 AdES, 8 sys, 9 bp, a RI, c Ov, d Tr, e ERET
- pc_i  in  32  M-stage instruction address
- in_delayslot_i  in  1  M-stage instruction is in a branch delay slot
- badaddr_i  in  32  faulting address for AdEL/AdES
- int_i  in  6  external hardware interrupt lines
- rdata_o  out  32  MFC0 read data, combinational from raddr_i
- status_o  out  32  Status
- cause_o  out  32  Cause
- epc_o  out  32  EPC, feeds cp0_epc in the hazard unit
- timer_int_o  out  1  Cause.TI

Behaviour:
Reset (async, resetn=0). All of the following apply immediately:
- Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare = 0.
- tick flop = 0; timer_int_o = 0.
- rdata_o follows the reset register contents.

Register map:
- BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15.
- Unmapped addresses read 0; writes to them are ignored.

Write masks:
- Status: only IM[15:8], EXL[1], IE[0] are writable.
- Cause: only IP[9:8] (software interrupts) is writable.
- EPC, Count, Compare: fully writable.
- BadVAddr, PRId: read-only.

Every cycle, regardless of en_i:
- Cause.IP[15:10] <= {int_i[5] | Cause.TI, int_i[4:0]}.

Commit (posedge, en_i=1), in priority order:
1. excepttype_i == 32'he (ERET): Status.EXL <= 0.
2. excepttype_i is any other nonzero code:
   - If Status.EXL==0: EPC <= in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD <= in_delayslot_i.
   - If Status.EXL==1: EPC and BD are held.
   - Status.EXL <= 1.
   - Cause.ExcCode[6:2] <= 0 for int, 4/5/8/9/a/c/d for the respective codes.
   - For 4/5 only, also BadVAddr <= badaddr_i.
3. Otherwise, if we_i: the masked MTC0 write to waddr_i.

Commit conflicts:
- An exception and MTC0 in the same cycle: the exception wins; the MTC0 write is dropped.
- en_i=0: exceptions and writes are ignored (held instruction, no double commit).

Timer:
- tick toggles every cycle; Count increments on cycles where tick==1 (once per 2 clk).
- MTC0 Count has priority over the increment.
- When Count==Compare (at the update) and Compare != 0: Cause.TI <= 1.
- MTC0 Compare clears TI in the same edge. Write beats a same-cycle match.
- Count wraps 32'hFFFFFFFF -> 0 with no side effect.

Reads:
- rdata_o is combinational from register state.
- No write-to-read bypass; a same-cycle MTC0 is visible on the next cycle.

Optional Feature:
- CP0_TIMER_EN defined: Count/Compare/TI behave as above.
- Undefined:
  - Count and Compare are not implemented and read 0; writes to them are ignored.
  - Cause.TI is constant 0; timer_int_o = 0; IP7 = int_i[5] only.

Decomposition:
- Shared package cp0_defs:
  - register number constants;
  - excepttype codes (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR, EXC_ERET);
  - ExcCode values;
  - Status/Cause bit positions and write masks;
  - exception vector 32'hBFC00380.
- One sub-module, cp0_timer:
  - contains the tick, Count, Compare and TI;
  - takes the write strobes;
  - is instantiated only under CP0_TIMER_EN.

Test Plan:
1. Reset, read regs 12/13/14 -> 32'h00400000 / 0 / 0; read 15 -> 32'h00004220.
2. excepttype=8, pc=32'hBFC00100, delayslot=0, EXL=0 -> EPC=32'hBFC00100, ExcCode=8, EXL=1, BD=0. Then excepttype=e -> EXL=0.
3. excepttype=4, pc=32'hBFC00208, delayslot=1, badaddr=32'h00000003 -> EPC=32'hBFC00204, BD=1, BadVAddr=32'h00000003. Second exception with EXL=1 leaves EPC unchanged.
4. MTC0 Status=32'hFFFFFFFF -> reads 32'h0040FF03. Same-cycle exception excepttype=c plus MTC0 EPC=32'h1234 -> EPC=pc_i, not 32'h1234. en_i=0 with excepttype=8 -> no change.
5. (CP0_TIMER_EN) MTC0 Compare=5, Count=0 -> TI=1 after ~10 cycles and Cause.IP7=1. MTC0 Compare=100 -> TI=0 next cycle.
6. Assert resetn low mid-run with Count=37, EXL=1 -> all registers return to reset values immediately, asynchronously.
